// File: rtl/mr_issue_ctl.sv
// mr_issue_ctl: gates decoded instructions into the one-cycle ALU.
// Issue is held off by a register scoreboard (RAW/WAW), an in-flight limit,
// and a branch-resolution wait that ends in a one-cycle flush when taken.
module mr_issue_ctl #(
    parameter int NREGS        = 32,
    parameter int REGSEL_BITS  = 5,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [REGSEL_BITS-1:0] dec_rs1,
    input  logic [REGSEL_BITS-1:0] dec_rs2,
    input  logic                   dec_rs1_used,
    input  logic                   dec_rs2_used,
    input  logic [REGSEL_BITS-1:0] dec_rd,
    input  logic                   dec_is_branch,
    output logic                   iss_valid,
    input  logic                   iss_ready,
    input  logic                   alu_jmp_done,
    input  logic                   alu_pc_valid,
    input  logic                   wb_valid,
    input  logic [REGSEL_BITS-1:0] wb_reg,
    output logic                   flush,
    output logic [NREGS-1:0]       busy_mask,
    output logic [31:0]            stall_cycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    state_t            state_q, state_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [3:0]        inflight_q, inflight_d;
    logic [31:0]       stall_q, stall_d;

    logic hz;
    logic go;
    logic fire;

    // Hazard detection and issue handshake; no same-cycle writeback bypass.
    always_comb begin
        hz = 1'b0;
        if (dec_rs1_used && (dec_rs1 != '0) && busy_q[dec_rs1]) hz = 1'b1;
        if (dec_rs2_used && (dec_rs2 != '0) && busy_q[dec_rs2]) hz = 1'b1;
        if ((dec_rd != '0) && busy_q[dec_rd])                   hz = 1'b1;
        if (inflight_q == MAX_CNT)                              hz = 1'b1;
        go        = (state_q == RUN) && !hz;
        dec_ready = iss_ready && go;
        iss_valid = dec_valid && go;
        fire      = dec_valid && dec_ready;
    end

    // Branch FSM next state: hold issue until the ALU resolves the branch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (fire && dec_is_branch) state_d = BR_WAIT;
            end
            BR_WAIT: begin
                if (alu_jmp_done) state_d = alu_pc_valid ? FLUSH : RUN;
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Scoreboard, in-flight count and stall counter next values.
    // Clear is applied before set so a same-index collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid && (wb_reg != '0)) busy_d[wb_reg] = 1'b0;
        if (fire && (dec_rd != '0))     busy_d[dec_rd] = 1'b1;
        busy_d[0] = 1'b0;

        inflight_d = inflight_q;
        if (fire && !wb_valid) begin
            inflight_d = inflight_q + 4'd1;
        end else if (!fire && wb_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - 4'd1;
        end

        stall_d = stall_q;
        if (dec_valid && !dec_ready) stall_d = stall_q + 32'd1;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            busy_q     <= '0;
            inflight_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
        end
    end

    assign flush        = (state_q == FLUSH);
    assign busy_mask    = busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mr_issue_ctl.sv
// Scoreboard bench for mr_issue_ctl: stimulus pushes expected issue and
// flush events (cycle, rd); a negedge monitor pops and compares them.
module tb_mr_issue_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rs1_used, dec_rs2_used;
    logic        dec_is_branch;
    logic        iss_valid;
    logic        iss_ready;
    logic        alu_jmp_done, alu_pc_valid;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        flush;
    logic [31:0] busy_mask;
    logic [31:0] stall_cycles;

    mr_issue_ctl #(
        .NREGS(32),
        .REGSEL_BITS(5),
        .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used),
        .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd),
        .dec_is_branch(dec_is_branch),
        .iss_valid(iss_valid),
        .iss_ready(iss_ready),
        .alu_jmp_done(alu_jmp_done),
        .alu_pc_valid(alu_pc_valid),
        .wb_valid(wb_valid),
        .wb_reg(wb_reg),
        .flush(flush),
        .busy_mask(busy_mask),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] rd;
    } iss_t;

    iss_t exp_iss[$];
    int   exp_fl[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   t0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every issue handshake and every flush cycle must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (dec_valid && dec_ready) begin
                total++;
                if (exp_iss.size() == 0) begin
                    bad++;
                    $display("FAIL issue: unexpected issue at cycle %0d rd=%0d", cyc, dec_rd);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    if (e.cyc != cyc || e.rd != dec_rd) begin
                        bad++;
                        $display("FAIL issue: got cycle %0d rd=%0d, expected cycle %0d rd=%0d",
                                 cyc, dec_rd, e.cyc, e.rd);
                    end
                end
            end
            if (flush) begin
                total++;
                if (exp_fl.size() == 0) begin
                    bad++;
                    $display("FAIL flush: unexpected flush at cycle %0d", cyc);
                end else begin
                    int f;
                    f = exp_fl.pop_front();
                    if (f != cyc) begin
                        bad++;
                        $display("FAIL flush: got cycle %0d, expected cycle %0d", cyc, f);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic br);
        dec_valid     = v;
        dec_rd        = rd;
        dec_rs1       = rs1;
        dec_rs1_used  = u1;
        dec_rs2       = rs2;
        dec_rs2_used  = u2;
        dec_is_branch = br;
    endtask

    task automatic wb(input logic v, input logic [4:0] r);
        wb_valid = v;
        wb_reg   = r;
    endtask

    task automatic jmp(input logic done, input logic taken);
        alu_jmp_done = done;
        alu_pc_valid = taken;
    endtask

    task automatic push(input int c, input logic [4:0] rd);
        iss_t e;
        e.cyc = c;
        e.rd  = rd;
        exp_iss.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iss_ready = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        jmp(0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", busy_mask, 32'h0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_stall", stall_cycles, 32'd0);
        chk("reset_ready", {31'd0, dec_ready}, 32'd1);

        // RAW: consumer of r5 stalls cycles 1-3, issues in cycle 4
        step(); t0 = cyc;
        drv(1, 5, 0, 0, 0, 0, 0); push(t0, 5);
        step(); drv(1, 6, 5, 1, 0, 0, 0); push(t0 + 4, 6);
        step();
        step(); wb(1, 5);
        step(); wb(0, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 0);
        chk("raw_stall", stall_cycles, 32'd3);
        chk("raw_busy", busy_mask, 32'h40);
        wb(1, 6);
        step(); wb(0, 0);
        chk("raw_busy_clear", busy_mask, 32'h0);

        // Register zero never creates a hazard
        step(); t0 = cyc;
        drv(1, 0, 0, 0, 0, 0, 0); push(t0, 0);
        step(); drv(1, 0, 0, 1, 0, 1, 0); push(t0 + 1, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 0); wb(1, 0);
        chk("zero_busy", busy_mask, 32'h0);
        step();
        step(); wb(0, 0);

        // Taken branch: flush in cycle 2, next issue in cycle 3
        step(); t0 = cyc;
        drv(1, 0, 0, 0, 0, 0, 1); push(t0, 0);
        step(); drv(1, 7, 0, 0, 0, 0, 0); jmp(1, 1); wb(1, 0);
        push(t0 + 3, 7); exp_fl.push_back(t0 + 2);
        step(); jmp(0, 0); wb(0, 0);
        step();
        step(); drv(0, 0, 0, 0, 0, 0, 0); wb(1, 7);
        step(); wb(0, 0);
        chk("taken_stall", stall_cycles, 32'd5);

        // Not-taken branch: no flush, issue resumes in cycle 2
        step(); t0 = cyc;
        drv(1, 0, 0, 0, 0, 0, 1); push(t0, 0);
        step(); drv(1, 8, 0, 0, 0, 0, 0); jmp(1, 0); wb(1, 0); push(t0 + 2, 8);
        step(); jmp(0, 0); wb(0, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 0); wb(1, 8);
        step(); wb(0, 0);
        chk("nottaken_stall", stall_cycles, 32'd6);
        chk("nottaken_flush", {31'd0, flush}, 32'd0);

        // In-flight limit: 5th waits for the first writeback
        step(); t0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            drv(1, 5'(i), 0, 0, 0, 0, 0);
            push(t0 + i - 1, 5'(i));
            step();
        end
        drv(1, 6, 0, 0, 0, 0, 0); wb(1, 1); push(t0 + 5, 6);
        step(); wb(0, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 0);
        chk("limit_busy", busy_mask, 32'h5C);
        wb(1, 2);
        step(); wb(1, 3); drv(1, 10, 0, 0, 0, 0, 0); push(t0 + 7, 10);
        step(); drv(0, 0, 0, 0, 0, 0, 0);
        chk("setclr_busy", busy_mask, 32'h450);
        chk("limit_stall", stall_cycles, 32'd7);
        wb(1, 4);
        step(); wb(1, 6);
        step(); wb(1, 10);
        step(); wb(1, 0);
        chk("drain_busy", busy_mask, 32'h0);

        // Spurious writeback at zero in-flight must not underflow the counter
        step(); wb(0, 0); t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 0, 0, 0);
            push(t0 + i, 0);
            step();
        end
        wb(1, 0); push(t0 + 5, 0);
        step(); wb(0, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 0); wb(1, 0);
        repeat (4) step();
        wb(0, 0);
        chk("underflow_stall", stall_cycles, 32'd8);

        // Asynchronous reset in the middle of BR_WAIT
        step(); t0 = cyc;
        drv(1, 12, 0, 0, 0, 0, 1); push(t0, 12);
        step(); drv(1, 11, 0, 0, 0, 0, 0);
        chk("pre_reset_busy", busy_mask, 32'h1000);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", busy_mask, 32'h0);
        chk("async_flush", {31'd0, flush}, 32'd0);
        chk("async_stall", stall_cycles, 32'd0);
        step(); rst = 1'b0;
        #0;
        chk("post_rst_ready", {31'd0, dec_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, iss_valid}, 32'd1);
        push(cyc, 11);
        step(); drv(0, 0, 0, 0, 0, 0, 0); wb(1, 11);
        step(); wb(0, 0);
        repeat (3) step();

        chk("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
        chk("flush_queue_empty", 32'(exp_fl.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mr_issue_ctl.md
# mr_issue_ctl

Issue controller between decode and the ALU stage. It gates each decoded instruction into the ALU with a register scoreboard that covers read-after-write and write-after-write hazards, plus an in-flight limit. After every branch or jump it holds issue until the ALU resolves it, then emits a one-cycle flush when the branch is taken. There is no forwarding and no speculation; the block only sequences the existing one-cycle ALU.

## Interface
Parameters:
- NREGS, 32: number of architectural registers; register 0 is hardwired zero.
- REGSEL_BITS, 5: register-select width, equal to log2(NREGS).
- MAX_INFLIGHT, 4: maximum number of instructions issued but not yet retired (range 1–15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  the instruction is accepted this cycle.
- dec_rs1, dec_rs2  in  REGSEL_BITS  source register indices.
- dec_rs1_used, dec_rs2_used  in  1  the corresponding source is read.
- dec_rd  in  REGSEL_BITS  destination register; 0 means no write.
- dec_is_branch  in  1  the instruction's branch op is not "never".
- iss_valid  out  1  drives the ALU's input-valid.
- iss_ready  in  1  the ALU's input-ready.
- alu_jmp_done  in  1  the ALU's branch-resolved pulse.
- alu_pc_valid  in  1  the ALU's branch-taken/redirect pulse.
- wb_valid  in  1  one instruction retires this cycle.
- wb_reg  in  REGSEL_BITS  destination of the retiring instruction (0 if none).
- flush  out  1  discard all younger fetched/decoded instructions.
- busy_mask  out  NREGS  scoreboard; bit i set means register i has a write pending.
- stall_cycles  out  32  performance counter.

## Operation
Hazard term, combinational:
- hz = (rs1_used & rs1≠0 & busy[rs1]) | (rs2_used & rs2≠0 & busy[rs2]) | (rd≠0 & busy[rd]) | (inflight == MAX_INFLIGHT).

Issue gating:
- go = (state == RUN) & ~hz.
- dec_ready = iss_ready & go.
- iss_valid = dec_valid & go.
- fire = dec_valid & dec_ready.

Scoreboard:
- On fire with rd≠0, set busy[rd].
- On wb_valid with wb_reg≠0, clear busy[wb_reg].
- Set and clear in the same cycle on different indices: both apply.
- Set and clear in the same cycle on the same index: set wins.
- Clearing a bit that is already 0 is a no-op.
- busy[0] is always 0.

In-flight counter (width 4):
- Increments on fire, decrements on wb_valid; both in one cycle leaves it unchanged.
- wb_valid while the counter is 0: the counter stays 0.
- Every issued instruction, including those with rd=0 and branches, retires with exactly one wb_valid.

Branch FSM states: RUN, BR_WAIT, FLUSH.
- RUN → BR_WAIT on fire with dec_is_branch=1; otherwise stay in RUN.
- BR_WAIT → FLUSH when alu_jmp_done=1 and alu_pc_valid=1.
- BR_WAIT → RUN when alu_jmp_done=1 and alu_pc_valid=0.
- BR_WAIT holds while alu_jmp_done=0.
- FLUSH → RUN unconditionally after one cycle.
- alu_jmp_done or alu_pc_valid arriving in RUN or FLUSH is ignored.
- flush = (state == FLUSH); it is decoded from a register and is glitch-free.

stall_cycles:
- Increments each cycle that dec_valid=1 and dec_ready=0; wraps modulo 2^32.

Reset, asserted at any time including mid-BR_WAIT: state=RUN, busy_mask=0, inflight=0, stall_cycles=0, flush=0. dec_ready then equals iss_ready, and iss_valid equals dec_valid.

## Timing
- Zero-latency issue: dec_* to iss_valid/dec_ready is combinational.
- A scoreboard set or clear becomes visible to hz in the cycle after the edge that writes it. There is no same-cycle writeback bypass.
- A dependent instruction issues at the earliest in the cycle after the producer's wb_valid.
- Branch fired in cycle N: the ALU pulses alu_jmp_done in cycle N+1, and dec_ready=0 in N+1.
  - Taken: flush=1 in N+2, issue is possible from N+3.
  - Not taken: issue is possible from N+2.
- An ALU stall (iss_ready=0) holds dec_ready low, and the scoreboard and counter do not change from issue.

## Test plan
- Reset: assert rst asynchronously mid-cycle with dec_valid=1 and iss_ready=1. Required: busy_mask=0, flush=0, stall_cycles=0 immediately; dec_ready=1 and iss_valid=1 once rst falls.
- RAW: issue rd=5 in cycle 0; in cycle 1 present rs1=5, rs1_used=1. Required: dec_ready=0 for cycles 1–3; wb_valid with wb_reg=5 in cycle 3; issue in cycle 4; stall_cycles=3.
- Register zero: issue rd=0, then rs1=0 and rs2=0 with both used. Required: back-to-back issue, busy_mask stays 0.
- Taken branch: fire a branch in cycle 0; in cycle 1 drive alu_jmp_done=1 and alu_pc_valid=1. Required: dec_ready=0 in cycles 1–2, flush=1 only in cycle 2, an independent instruction issues in cycle 3.
- Not-taken branch: same as above with alu_pc_valid=0. Required: flush never asserts, issue resumes in cycle 2.
- In-flight limit: with MAX_INFLIGHT=4, issue 4 independent instructions (rd=1..4) in cycles 0–3. Required: the 5th is stalled until the cycle after the first wb_valid. Also drive an issue with rd=6 together with wb_valid for wb_reg=1 in the same cycle; required: busy_mask=0x5C afterwards.
